// File: rtl/umi_arbiter_mux_if.sv
// UMI N-to-1 arbiter bus bundle: per-port request side plus the merged output stream.
// The slave modport is the arbiter's view; master is the view of sources and downstream sink.
interface umi_arbiter_mux_if #(
    parameter int N  = 4,
    parameter int UW = 256
);
    localparam int SW = $clog2(N);

    logic [N-1:0]    umi_in_valid;
    logic [N*UW-1:0] umi_in_packet;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [UW-1:0]   umi_out_packet;
    logic [SW-1:0]   umi_out_src;
    logic            umi_out_ready;
    logic [15:0]     stall_count;

    modport slave (
        input  umi_in_valid, umi_in_packet, umi_out_ready,
        output umi_in_ready, umi_out_valid, umi_out_packet, umi_out_src, stall_count
    );

    modport master (
        output umi_in_valid, umi_in_packet, umi_out_ready,
        input  umi_in_ready, umi_out_valid, umi_out_packet, umi_out_src, stall_count
    );
endinterface

// File: rtl/umi_arbiter_mux.sv
// Round-robin, packet-atomic N-to-1 UMI arbiter with one registered output stage.
// Optional saturating output-stall counter: define UMI_ARBITER_MUX_STALL_CNT_EN.
module umi_arbiter_mux #(
    parameter int N  = 4,
    parameter int UW = 256
) (
    input  logic              clk,
    input  logic              nreset,
    umi_arbiter_mux_if.slave  bus
);
    localparam int SW = $clog2(N);

    logic          out_valid_q;
    logic [UW-1:0] out_packet_q;
    logic [SW-1:0] out_src_q;
    logic [SW-1:0] last_q;
    logic          active_q;

    logic          load;
    logic          found;
    logic [SW-1:0] idx;
    logic [SW-1:0] gidx;
    logic [N-1:0]  grant;
    logic [UW-1:0] pkt_sel;
    logic          xfer;

    // active_q holds ready low through reset and the deasserting edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) active_q <= 1'b0;
        else         active_q <= 1'b1;
    end

    assign load = ~out_valid_q | bus.umi_out_ready;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        gidx    = '0;
        grant   = '0;
        pkt_sel = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = last_q + SW'(k);
            if (!found && bus.umi_in_valid[idx]) begin
                found       = 1'b1;
                gidx        = idx;
                grant[idx]  = 1'b1;
                pkt_sel     = bus.umi_in_packet[idx*UW +: UW];
            end
        end
    end

    assign bus.umi_in_ready = grant & {N{load & active_q}};
    assign xfer             = |bus.umi_in_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            last_q      <= SW'(N - 1);
        end else if (load && active_q) begin
            out_valid_q <= xfer;
            if (xfer) begin
                out_src_q <= gidx;
                last_q    <= gidx;
            end
        end
    end

    // Packet register is deliberately unreset; out_valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (xfer) out_packet_q <= pkt_sel;
    end

    assign bus.umi_out_valid  = out_valid_q;
    assign bus.umi_out_packet = out_packet_q;
    assign bus.umi_out_src    = out_src_q;

`ifdef UMI_ARBITER_MUX_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stall_q <= '0;
        end else if (out_valid_q && !bus.umi_out_ready && stall_q != '1) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_count = stall_q;
`else
    assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_umi_arbiter_mux.sv
// Directed self-checking bench for umi_arbiter_mux (N=4, UW=256).
module tb_umi_arbiter_mux;
    localparam int N  = 4;
    localparam int UW = 256;

    logic clk = 1'b0;
    logic nreset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    umi_arbiter_mux_if #(.N(N), .UW(UW)) u_if ();

    umi_arbiter_mux #(.N(N), .UW(UW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (u_if)
    );

    function automatic logic [UW-1:0] pat(input logic [7:0] b);
        return {(UW/8){b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int p, input logic [7:0] b);
        u_if.umi_in_packet[p*UW +: UW] = pat(b);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        u_if.umi_in_valid  = '0;
        u_if.umi_out_ready = 1'b1;
        tick();
        nreset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        u_if.umi_out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_pkt(i, 8'h10 + 8'(i));
        u_if.umi_in_valid = 4'hF;
        tick();
        tick();
        checks++; if (u_if.umi_in_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %h want 0", u_if.umi_in_ready); end
        checks++; if (u_if.umi_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", u_if.umi_out_valid); end
        checks++; if (u_if.umi_out_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", u_if.umi_out_src); end
        checks++; if (u_if.stall_count !== 16'h0) begin errors++; $display("FAIL reset_stall got %h want 0", u_if.stall_count); end
        u_if.umi_in_valid = '0;
        nreset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single();
        set_pkt(2, 8'hA5);
        u_if.umi_in_valid = 4'b0100;
        #1;
        checks++; if (u_if.umi_in_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", u_if.umi_in_ready); end
        tick();
        u_if.umi_in_valid = '0;
        checks++; if (u_if.umi_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", u_if.umi_out_valid); end
        checks++; if (u_if.umi_out_packet !== pat(8'hA5)) begin errors++; $display("FAIL single_packet got %h want a5..", u_if.umi_out_packet[7:0]); end
        checks++; if (u_if.umi_out_src !== 2'd2) begin errors++; $display("FAIL single_src got %0d want 2", u_if.umi_out_src); end
        tick();
        checks++; if (u_if.umi_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", u_if.umi_out_valid); end
    endtask

    task automatic test_contention();
        int          cnt[N];
        logic [3:0]  exp_rdy;
        do_reset();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            set_pkt(i, 8'h10 + 8'(i));
        end
        u_if.umi_in_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_rdy = 4'b0001 << (c % 4);
            checks++; if (u_if.umi_in_ready !== exp_rdy) begin errors++; $display("FAIL cont_ready c=%0d got %b want %b", c, u_if.umi_in_ready, exp_rdy); end
            for (int i = 0; i < N; i++) cnt[i] += int'(u_if.umi_in_ready[i]);
            tick();
            checks++; if (u_if.umi_out_src !== 2'(c % 4)) begin errors++; $display("FAIL cont_src c=%0d got %0d want %0d", c, u_if.umi_out_src, c % 4); end
            checks++; if (u_if.umi_out_valid !== 1'b1) begin errors++; $display("FAIL cont_bubble c=%0d got %b want 1", c, u_if.umi_out_valid); end
            checks++; if (u_if.umi_out_packet !== pat(8'h10 + 8'(c % 4))) begin errors++; $display("FAIL cont_packet c=%0d got %h want %h", c, u_if.umi_out_packet[7:0], 8'h10 + 8'(c % 4)); end
        end
        u_if.umi_in_valid = '0;
        for (int i = 0; i < N; i++) begin
            checks++; if (cnt[i] !== 2) begin errors++; $display("FAIL cont_count port=%0d got %0d want 2", i, cnt[i]); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        set_pkt(1, 8'hC3);
        u_if.umi_in_valid = 4'b0010;
        #1;
        checks++; if (u_if.umi_in_ready !== 4'b0010) begin errors++; $display("FAIL bp_load_ready got %b want 0010", u_if.umi_in_ready); end
        tick();
        checks++; if (u_if.umi_out_src !== 2'd1) begin errors++; $display("FAIL bp_load_src got %0d want 1", u_if.umi_out_src); end
        u_if.umi_in_valid  = 4'b1001;
        u_if.umi_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (u_if.umi_in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c=%0d got %b want 0000", c, u_if.umi_in_ready); end
            tick();
            checks++; if (u_if.umi_out_packet !== pat(8'hC3) || u_if.umi_out_src !== 2'd1 || u_if.umi_out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold c=%0d got src %0d pkt %h v %b want src 1 pkt c3 v 1", c, u_if.umi_out_src, u_if.umi_out_packet[7:0], u_if.umi_out_valid);
            end
        end
`ifdef UMI_ARBITER_MUX_STALL_CNT_EN
        checks++; if (u_if.stall_count !== 16'd5) begin errors++; $display("FAIL bp_stall got %0d want 5", u_if.stall_count); end
`else
        checks++; if (u_if.stall_count !== 16'd0) begin errors++; $display("FAIL bp_stall got %0d want 0", u_if.stall_count); end
`endif
        u_if.umi_out_ready = 1'b1;
        #1;
        checks++; if (u_if.umi_in_ready !== 4'b1000) begin errors++; $display("FAIL bp_resume_ready got %b want 1000", u_if.umi_in_ready); end
        tick();
        checks++; if (u_if.umi_out_src !== 2'd3 || u_if.umi_out_packet !== pat(8'h13)) begin errors++; $display("FAIL bp_resume_src got %0d want 3", u_if.umi_out_src); end
        u_if.umi_in_valid = 4'b0001;
        #1;
        checks++; if (u_if.umi_in_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_ready got %b want 0001", u_if.umi_in_ready); end
        tick();
        checks++; if (u_if.umi_out_src !== 2'd0) begin errors++; $display("FAIL bp_next_src got %0d want 0", u_if.umi_out_src); end
        u_if.umi_in_valid = '0;
        tick();
        checks++; if (u_if.umi_out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", u_if.umi_out_valid); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        for (int c = 0; c < 8; c++) begin
            u_if.umi_in_valid = {(c % 2 == 0), 2'b00, 1'b1};
            exp_rdy = (c % 2 == 0) ? 4'b1000 : 4'b0001;
            #1;
            checks++; if (u_if.umi_in_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready c=%0d got %b want %b", c, u_if.umi_in_ready, exp_rdy); end
            tick();
            checks++; if (u_if.umi_out_src !== ((c % 2 == 0) ? 2'd3 : 2'd0)) begin errors++; $display("FAIL fair_src c=%0d got %0d", c, u_if.umi_out_src); end
        end
        u_if.umi_in_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        int waited;
        for (int i = 0; i < N; i++) set_pkt(i, 8'h10 + 8'(i));
        u_if.umi_in_valid = 4'b0100;
        tick();
        u_if.umi_in_valid = '0;
        checks++; if (u_if.umi_out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", u_if.umi_out_valid); end
        #2;
        u_if.umi_in_valid = 4'hF;
        nreset = 1'b0;
        #1;
        checks++; if (u_if.umi_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async got %b want 0", u_if.umi_out_valid); end
        checks++; if (u_if.umi_in_ready !== 4'h0) begin errors++; $display("FAIL rmid_ready got %b want 0", u_if.umi_in_ready); end
        tick();
        nreset = 1'b1;
        waited = 0;
        while (u_if.umi_out_valid !== 1'b1 && waited < 6) begin
            tick();
            waited++;
        end
        checks++; if (u_if.umi_out_valid !== 1'b1) begin errors++; $display("FAIL rmid_timeout got valid %b want 1", u_if.umi_out_valid); end
        checks++; if (u_if.umi_out_src !== 2'd0 || u_if.umi_out_packet !== pat(8'h10)) begin errors++; $display("FAIL rmid_first got src %0d want 0", u_if.umi_out_src); end
        u_if.umi_in_valid = '0;
        tick();
    endtask

    task automatic test_stall_count();
        do_reset();
        set_pkt(1, 8'h5A);
        u_if.umi_in_valid = 4'b0010;
        tick();
        u_if.umi_in_valid  = '0;
        u_if.umi_out_ready = 1'b0;
`ifdef UMI_ARBITER_MUX_STALL_CNT_EN
        repeat (100) tick();
        checks++; if (u_if.stall_count !== 16'd100) begin errors++; $display("FAIL stall_mid got %0d want 100", u_if.stall_count); end
        repeat (70000) tick();
        checks++; if (u_if.stall_count !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %h want ffff", u_if.stall_count); end
        tick();
        checks++; if (u_if.stall_count !== 16'hFFFF || u_if.umi_out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got %h want ffff", u_if.stall_count); end
`else
        repeat (20) tick();
        checks++; if (u_if.stall_count !== 16'd0) begin errors++; $display("FAIL stall_off got %0d want 0", u_if.stall_count); end
`endif
        checks++; if (u_if.umi_out_src !== 2'd1 || u_if.umi_out_packet !== pat(8'h5A)) begin errors++; $display("FAIL stall_data got src %0d want 1", u_if.umi_out_src); end
        u_if.umi_out_ready = 1'b1;
        tick();
    endtask

    initial begin
        nreset             = 1'b0;
        u_if.umi_in_valid  = '0;
        u_if.umi_in_packet = '0;
        u_if.umi_out_ready = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_stall_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
